// File: rtl/mips_seq_ctrl.sv
// mips_seq_ctrl: multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the MIPS datapath.
// It issues per-cycle datapath strobes, runs memory accesses over a req/ready
// handshake with a bounded wait, and counts retired instructions.
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   run_i                         start/continue; sampled in IDLE and at retire
//   opcode_i, funct_i             IR[31:26], IR[5:0]
//   zero_i                        ALU zero flag (used in EXEC for branches)
//   mem_ready_i                   memory completes the current access this cycle
//   mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
//   alu_src_a_o, alu_src_b_o, alu_ctrl_o, reg_write_o, reg_dst_o,
//   mem_to_reg_o                  datapath strobes
//   state_o, error_o, retired_count_o  status
module mips_seq_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             iord_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_ctrl_o,
  output logic             reg_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic [2:0]       state_o,
  output logic             error_o,
  output logic [CNT_W-1:0] retired_count_o
);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } state_e;
  state_e state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic retire, timeout;
  logic is_r, is_addi, is_lw, is_sw, is_beq, is_bne, is_j, legal;
  assign is_r    = opcode_i == 6'd0;
  assign is_addi = opcode_i == 6'd8;
  assign is_lw   = opcode_i == 6'd35;
  assign is_sw   = opcode_i == 6'd43;
  assign is_beq  = opcode_i == 6'd4;
  assign is_bne  = opcode_i == 6'd5;
  assign is_j    = opcode_i == 6'd2;
  assign legal   = is_r | is_addi | is_lw | is_sw | is_beq | is_bne | is_j;
  // This is the last permitted waiting cycle: a further miss now would hit the limit.
  assign timeout = wait_q == WW'(MEM_TIMEOUT - 1);
  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    mem_req_o    = 1'b0;
    iord_o       = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 2'b00;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_ctrl_o   = 3'b000;
    reg_write_o  = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state_q)
      S_IDLE: state_d = run_i ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        alu_ctrl_o  = ALU_ADD;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
        state_d     = mem_ready_i ? S_DECODE : timeout ? S_ERR : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b_o = 2'b11;
        alu_ctrl_o  = ALU_ADD;
        state_d     = legal ? S_EXEC : S_ERR;
      end
      S_EXEC: begin
        if (is_r) begin
          alu_src_a_o = 1'b1;
          alu_ctrl_o  = funct_i == 6'd1 ? ALU_SUB : ALU_ADD;
          state_d     = funct_i <= 6'd1 ? S_WB : S_ERR;
        end else if (is_addi | is_lw | is_sw) begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_ctrl_o  = ALU_ADD;
          state_d     = is_addi ? S_WB : S_MEM;
        end else if (is_beq | is_bne) begin
          alu_src_a_o = 1'b1;
          alu_ctrl_o  = ALU_SUB;
          pc_src_o    = 2'b01;
          pc_write_o  = is_beq ? zero_i : !zero_i;
          retire      = 1'b1;
        end else if (is_j) begin
          pc_src_o    = 2'b10;
          pc_write_o  = 1'b1;
          retire      = 1'b1;
        end else begin
          state_d     = S_ERR;
        end
      end
      S_MEM: begin
        mem_req_o   = 1'b1;
        iord_o      = 1'b1;
        mem_write_o = is_sw;
        retire      = mem_ready_i & is_sw;
        state_d     = mem_ready_i ? S_WB : timeout ? S_ERR : S_MEM;
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = is_r;
        mem_to_reg_o = is_lw;
        retire       = 1'b1;
      end
      S_ERR: state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (retire) state_d = run_i ? S_FETCH : S_IDLE;
  end
  // Any state change clears the wait counter, which covers entry to FETCH and MEM.
  assign wait_d = state_d != state_q ? '0 : (mem_req_o && !mem_ready_i) ? wait_q + WW'(1) : wait_q;
  assign cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end
  assign state_o         = state_q;
  assign error_o         = state_q == S_ERR;
  assign retired_count_o = cnt_q;
endmodule

// File: tb/tb_mips_seq_ctrl.sv
// tb_mips_seq_ctrl: scoreboard bench for mips_seq_ctrl against a per-instruction cycle model.
module tb_mips_seq_ctrl;
  localparam int TO = 3;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] SUB = 3'b110;
  logic clk = 1'b0;
  logic rst_ni, run_i, zero_i, mem_ready_i;
  logic [5:0] opcode_i, funct_i;
  logic mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic alu_src_a_o, reg_write_o, reg_dst_o, mem_to_reg_o, error_o;
  logic [2:0] alu_ctrl_o, state_o;
  logic [3:0] retired_count_o;
  mips_seq_ctrl #(.CNT_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .run_i(run_i), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .iord_o(iord_o),
    .mem_write_o(mem_write_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_ctrl_o(alu_ctrl_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .state_o(state_o), .error_o(error_o),
    .retired_count_o(retired_count_o)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic       rn, rdy, zr, msk;
    logic [5:0] op, fn;
    logic [2:0] st;
    logic       req, iord, mw, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] alu;
    logic       rw, rd, m2r, err;
    logic [3:0] cnt;
  } cyc_t;
  cyc_t q[$];
  cyc_t mr;
  int checks = 0, errors = 0;
  int unsigned cnt_m;
  bit idle_m;
  logic [5:0] cur_op, cur_fn;
  logic [23:0] act_v, exp_v, msk_v;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mr = q.pop_front();
      exp_v = {mr.st, mr.req, mr.iord, mr.mw, mr.irw, mr.pcw, mr.pcs, mr.asa, mr.asb, mr.alu,
               mr.rw, mr.rd, mr.m2r, mr.err, mr.cnt};
      act_v = {state_o, mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, pc_src_o,
               alu_src_a_o, alu_src_b_o, alu_ctrl_o, reg_write_o, reg_dst_o, mem_to_reg_o,
               error_o, retired_count_o};
      msk_v = mr.msk ? 24'hFFF8FF : 24'hFFFFFF;
      checks++;
      if ((act_v & msk_v) !== (exp_v & msk_v)) begin
        errors++;
        $display("FAIL cycle st=%0d op=%0d: got %h want %h (state,req,iord,mw,irw,pcw,pcs,asa,asb,alu,rw,rd,m2r,err,cnt)",
                 mr.st, mr.op, act_v, exp_v);
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic cyc_t mk(input logic [2:0] st);
    cyc_t r;
    r = '0;
    r.st = st;
    r.err = st == 3'd6;
    r.cnt = cnt_m[3:0];
    r.rn = 1'($urandom);
    r.rdy = 1'($urandom);
    r.zr = 1'($urandom);
    r.op = cur_op;
    r.fn = cur_fn;
    return r;
  endfunction
  function automatic cyc_t acc(input bit fetch);
    cyc_t r;
    r = mk(fetch ? 3'd1 : 3'd4);
    r.req = 1;
    r.iord = !fetch;
    r.mw = !fetch && cur_op == 6'd43;
    r.asb = fetch ? 2'b01 : 2'b00;
    r.alu = fetch ? ADD : 3'b000;
    return r;
  endfunction
  task automatic step(input cyc_t r);
    @(posedge clk);
    #1;
    run_i = r.rn;
    mem_ready_i = r.rdy;
    zero_i = r.zr;
    opcode_i = r.op;
    funct_i = r.fn;
    q.push_back(r);
  endtask
  task automatic access(input bit fetch, input int w, output bit to);
    cyc_t r;
    to = 0;
    for (int i = 0; i < w; i++) begin
      r = acc(fetch);
      r.rdy = 0;
      step(r);
      if (i == TO - 1) begin
        to = 1;
        break;
      end
    end
  endtask
  task automatic die();
    repeat (3) step(mk(3'd6));
  endtask
  task automatic retire(input bit er);
    cnt_m++;
    idle_m = !er;
  endtask
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input bit zr, input int fw,
                       input int mw, input bit er, input bit ab, output bit died);
    cyc_t r;
    bit to;
    died = 0;
    cur_op = op;
    cur_fn = fn;
    if (idle_m) begin
      repeat ($urandom_range(0, 2)) begin
        r = mk(3'd0);
        r.rn = 0;
        step(r);
      end
      r = mk(3'd0);
      r.rn = 1;
      step(r);
    end
    access(1, fw, to);
    if (to) begin die(); died = 1; return; end
    r = acc(1);
    r.rdy = 1;
    r.irw = 1;
    r.pcw = 1;
    step(r);
    r = mk(3'd2);
    r.asb = 2'b11;
    r.alu = ADD;
    step(r);
    if (!(op inside {6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2})) begin die(); died = 1; return; end
    r = mk(3'd3);
    r.asa = 1;
    if (op == 6'd0) begin
      r.alu = fn == 6'd1 ? SUB : ADD;
      r.msk = fn > 6'd1;
    end else if (op inside {6'd8, 6'd35, 6'd43}) begin
      r.asb = 2'b10;
      r.alu = ADD;
    end else if (op == 6'd4 || op == 6'd5) begin
      r.alu = SUB;
      r.pcs = 2'b01;
      r.zr = zr;
      r.pcw = op == 6'd4 ? zr : !zr;
      r.rn = er;
    end else begin
      r.asa = 0;
      r.pcw = 1;
      r.pcs = 2'b10;
      r.rn = er;
    end
    step(r);
    if (op == 6'd0 && fn > 6'd1) begin die(); died = 1; return; end
    if (op inside {6'd4, 6'd5, 6'd2}) begin retire(er); return; end
    if (op inside {6'd35, 6'd43}) begin
      if (ab) begin
        r = acc(0);
        r.rdy = 0;
        step(r);
        return;
      end
      access(0, mw, to);
      if (to) begin die(); died = 1; return; end
      r = acc(0);
      r.rdy = 1;
      if (op == 6'd43) begin
        r.rn = er;
        step(r);
        retire(er);
        return;
      end
      step(r);
    end
    r = mk(3'd5);
    r.rw = 1;
    r.rd = op == 6'd0;
    r.m2r = op == 6'd35;
    r.rn = er;
    step(r);
    retire(er);
  endtask
  task automatic drain();
    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    #1;
    chk("drain", q.size(), 0);
  endtask
  task automatic do_reset();
    run_i = 0;
    rst_ni = 0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_count", retired_count_o, 0);
    chk("rst_strobes", {mem_req_o, iord_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o}, 0);
    @(posedge clk);
    #1;
    rst_ni = 1;
    cnt_m = 0;
    idle_m = 1;
    q.delete();
  endtask
  task automatic go(input logic [5:0] op, input logic [5:0] fn, input bit zr, input int fw,
                    input int mw, input bit er);
    bit died;
    instr(op, fn, zr, fw, mw, er, 0, died);
    if (died) begin
      drain();
      do_reset();
    end
  endtask
  logic [5:0] ops [7] = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2};
  initial begin
    bit died;
    int k, j;
    logic [5:0] op, fn;
    rst_ni = 1;
    run_i = 0;
    zero_i = 0;
    mem_ready_i = 0;
    opcode_i = 0;
    funct_i = 0;
    #1;
    do_reset();
    go(6'd0, 6'd0, 0, 0, 0, 1);
    go(6'd35, 6'd0, 0, 2, 1, 1);
    go(6'd4, 6'd0, 1, 0, 0, 1);
    go(6'd4, 6'd0, 0, 0, 0, 1);
    go(6'd5, 6'd0, 1, 1, 0, 1);
    go(6'd8, 6'd0, 0, 0, 0, 0);
    go(6'd63, 6'd0, 0, 0, 0, 1);
    go(6'd0, 6'd7, 0, 0, 0, 1);
    go(6'd43, 6'd0, 0, 0, 3, 1);
    go(6'd43, 6'd0, 0, 0, 2, 1);
    go(6'd35, 6'd0, 0, 3, 0, 1);
    for (int i = 0; i < 18; i++) go(6'd2, 6'd0, 0, 0, 0, 1);
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 29);
      j = $urandom_range(0, 15);
      op = k < 28 ? ops[k % 7] : (k == 28 ? 6'd63 : 6'd17);
      fn = op == 6'd0 ? (j == 0 ? 6'd7 : {5'd0, j[0]}) : 6'($urandom);
      go(op, fn, 1'($urandom),
         $urandom_range(0, 24) == 0 ? TO : $urandom_range(0, TO - 1),
         $urandom_range(0, 24) == 0 ? TO : $urandom_range(0, TO - 1),
         $urandom_range(0, 4) != 0);
    end
    instr(6'd43, 6'd0, 0, 0, 0, 1, 1, died);
    @(negedge clk);
    #1;
    chk("pre_reset_mem_write", {state_o, mem_write_o}, {3'd4, 1'b1});
    do_reset();
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_seq_ctrl.md
# mips_seq_ctrl

Multicycle sequencing controller for the MIPS datapath: register file, data memory, program memory and ALU. Each instruction is stepped through FETCH/DECODE/EXEC/MEM/WB, and the block issues per-cycle datapath strobes. Memory accesses use a req/ready handshake with a bounded wait, and retired instructions are counted. It replaces the single-cycle decode in the top-level core.

## Interface
- CNT_W, 16, width of retired-instruction counter
- MEM_TIMEOUT, 15, max cycles `mem_ready` may stay low during an access before error (must be ≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- run  in  1  start/continue execution; sampled only in IDLE and at retire
- opcode  in  6  IR[31:26]; stable from the cycle after FETCH completes
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access active
- iord  out  1  0 = PC addresses memory (fetch), 1 = ALUOut (data)
- mem_write  out  1  write strobe (sw)
- ir_write  out  1  load IR
- pc_write  out  1  load PC
- pc_src  out  2  00 PC+4 (ALU), 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 PC, 1 rs data
- alu_src_b  out  2  00 rt data, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- alu_ctrl  out  3  010 ADD, 110 SUB
- reg_write  out  1  register-file write strobe
- reg_dst  out  1  1 rd, 0 rt
- mem_to_reg  out  1  1 memory word, 0 ALUOut
- state  out  3  current state code
- error  out  1  sticky; set on illegal instruction or memory timeout
- retired_count  out  CNT_W  instructions retired, wraps mod 2^CNT_W

## Operation
- States and codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6. Codes 7 and unused go to ERR.
- Strobes are combinational from state, opcode, funct, zero and mem_ready. Any strobe not listed for a state is 0, and all strobes are 0 in IDLE and ERR.
- IDLE: if run=1, go to FETCH.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target latched into ALUOut by the datapath).
  - Legal opcodes go to EXEC: 0 R-type, 8 addi, 35 lw, 43 sw, 4 beq, 5 bne, 2 j.
  - Any other opcode goes to ERR.
- EXEC:
  - R-type: alu_src_a=1, alu_src_b=00, funct 0 selects ADD, funct 1 selects SUB; go to WB. Any other funct goes to ERR.
  - addi, lw, sw: alu_src_a=1, alu_src_b=10, ADD. addi goes to WB; lw and sw go to MEM.
  - beq/bne: alu_src_a=1, alu_src_b=00, SUB, pc_src=01. pc_write=zero for beq and !zero for bne. Then retire.
  - j: pc_write=1, pc_src=10, then retire.
- MEM: mem_req=1, iord=1, mem_write=1 for sw only. Stay until mem_ready. On ready, lw goes to WB and sw retires.
- WB: reg_write=1. R-type: reg_dst=1, mem_to_reg=0. addi: reg_dst=0, mem_to_reg=0. lw: reg_dst=0, mem_to_reg=1. Then retire.
- Retire: on the leaving edge, retired_count increments by 1; next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction has no effect until retire.
- Timeout: wait counter clears on entry to FETCH or MEM and increments each cycle mem_req=1 && mem_ready=0. If it reaches MEM_TIMEOUT while still waiting, go to ERR. A mem_ready in the same cycle as the final count wins.
- ERR: error=1, holds until reset.
- Reset (any time, including mid-access): state=IDLE, error=0, retired_count=0, wait counter=0, all strobes 0 immediately and asynchronously.

## Timing
- Cycles per instruction with mem_ready high on first request: R/addi 4, lw 5, sw 4, beq/bne/j 3.
- Each cycle mem_ready is held low adds 1 cycle in FETCH or MEM.
- IDLE→FETCH takes 1 cycle after run is seen high.
- retired_count updates on the clock edge that leaves the final state.
- error rises the cycle ERR is entered.

## Test plan
- Reset low then release with run=1, mem_ready=1, R-type add (opcode 0, funct 0): states 0,1,2,3,5,1. reg_write=1 and reg_dst=1 in WB; retired_count 0→1 on leaving WB.
- lw (35) with mem_ready low 2 cycles in FETCH and 1 cycle in MEM: 8 cycles total; mem_to_reg=1 and reg_write=1 in WB; iord=1 in MEM.
- beq (4) with zero=1, then with zero=0: pc_write=1 then 0 in EXEC, pc_src=01 both times; both retire in 3 cycles.
- Illegal opcode 63, then R-type funct 7: each ends in ERR with error=1 and retired_count unchanged; run toggling is ignored until reset.
- MEM_TIMEOUT=3, sw with mem_ready stuck low: ERR after 3 waiting cycles in MEM. Repeat with mem_ready on the 3rd cycle: the instruction retires normally.
- Drop run during EXEC of addi: WB completes, retired_count increments, state goes to IDLE. Assert reset in MEM of sw: mem_write drops immediately, state=0.
